cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU, directly upstream of the ALU.
- Fetches 16-bit instructions over a req/ack memory port and fetches operands into an operand register that drives the ALU [X] input.
- Drives the ALU function code and the C7/C14 zero-gating controls, and pulses the ACC write enable.
- Performs stores, jumps and halt itself.
- Instruction format: [15:8] opcode, [7:0] address.

Parameters:
- ADDR_W, 8, memory and PC address width; must be ≤ 8.
- DATA_W, 16, data and instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  memory address, stable while mem_rd or mem_wr is high.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  DATA_W  store data (the ACC value).
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  completes the current request.
- acc_num  in  DATA_W  current ACC value, used for stores and the JMPGE sign test.
- fn  out  9  ALU function code; bit 8 is always 0.
- c7  out  1  ALU ACC-input zero gate.
- c14  out  1  ALU [X]-input zero gate.
- alu_x  out  DATA_W  operand register, wired to the ALU [X] input.
- acc_we  out  1  one-cycle ACC load strobe.
- pc  out  ADDR_W  program counter.
- halted  out  1  high once HALT has executed.

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, ir=0, alu_x=0, fn=0, c7=1, c14=1.
- Reset: mem_rd=mem_wr=acc_we=0, mem_addr=0, halted=0.
- rst in any state (including mid-handshake) aborts the operation and drops requests the next edge.
- Handshake: the request and mem_addr are held until mem_ack is sampled high.
  - Ack may arrive in the same cycle as the request.
  - Read data is captured in the ack cycle, and the request deasserts on the following edge.
  - mem_ack with no request pending is ignored.
- FETCH: mem_rd=1, mem_addr=pc. On ack, ir<=mem_rdata and pc<=pc+1 (wrapping 0xFF→0x00), then go to DECODE.
- DECODE: one cycle, dispatches on ir[15:8]:
  - 0x02, 0x03, 0x04, 0x08–0x0C go to OPERAND.
  - 0x01 goes to STORE.
  - 0x05, 0x06 go to JUMP.
  - 0x07 goes to HALT.
  - 0x0D–0x0F go to EXECUTE.
  - Any other opcode is a NOP and goes to FETCH.
- OPERAND: mem_rd=1, mem_addr=ir[7:0]. On ack, alu_x<=mem_rdata, then go to EXECUTE.
- EXECUTE: one cycle.
  - fn={1'b0,opcode} and acc_we=1.
  - c7=1 for opcodes 0x02 and 0x0C, else 0.
  - c14=1 for opcodes 0x0D–0x0F, else 0.
  - Then go to FETCH.
- Outside EXECUTE: fn=0, c7=c14=1, acc_we=0.
- STORE: mem_wr=1, mem_addr=ir[7:0], mem_wdata=acc_num (sampled when entering STORE). On ack, go to FETCH.
- JUMP: one cycle.
  - 0x06: pc<=ir[7:0].
  - 0x05: pc<=ir[7:0] if acc_num[15]==0, else pc is unchanged (already incremented).
  - Then go to FETCH.
- HALT: halted=1, no requests issued. Only rst exits this state.
- Latency with zero-wait memory:
  - Operand ops take 4 cycles.
  - Register-only ALU ops take 3 cycles.
  - Store takes 3 cycles.
  - Jump takes 3 cycles.
  - NOP takes 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Divide by zero: EXECUTE runs normally. The controller does not check the operand.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined: adds input port step (1 bit). FETCH does not assert mem_rd until a cycle with step=1 is seen. One pulse executes exactly one instruction; extra pulses mid-instruction are ignored.
- When undefined: no step port, and fetch proceeds immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_STORE=0x01 … OP_NOTACC=0x0F;
  - the state enum (FETCH, DECODE, OPERAND, EXECUTE, STORE, JUMP, HALT);
  - the ADDR_W/DATA_W defaults.
- Sub-module cpu_opcode_decode (combinational): takes the opcode and produces needs_operand, writes_acc, gate_acc (c7), gate_x (c14), is_store, is_jump, is_halt.

Test Plan:
- Reset, then mem[0]=0x0210 and mem[0x10]=0x1234, zero-wait memory → EXECUTE at cycle 4 with fn=0x002, c7=1, c14=0, alu_x=0x1234, acc_we=1, pc=1.
- mem[1]=0x0111, acc_num=0xBEEF, ack delayed 3 cycles → mem_wr held 4 cycles at addr 0x11 with wdata=0xBEEF, and no acc_we.
- Opcode 0x0540 run twice, with acc_num=0x0001 then acc_num=0x8000 → pc=0x40 the first time; the second time pc is the instruction address+1.
- pc=0xFF fetches 0x0D00 → pc wraps to 0x00, EXECUTE fn=0x00D with c14=1 and no operand read.
- Opcode 0x0700 → halted=1, no mem_rd for 20 cycles; rst pulse → pc=0, halted=0, fetch resumes.
- rst asserted in OPERAND while waiting for ack → next cycle mem_rd=0 and state=FETCH; opcode 0xAA gives a NOP with no acc_we.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer state encoding and default widths for the accumulator CPU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGE  = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_DIV    = 8'h09;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOTX   = 8'h0C;
    localparam logic [7:0] OP_SHL    = 8'h0D;
    localparam logic [7:0] OP_SHR    = 8'h0E;
    localparam logic [7:0] OP_NOTACC = 8'h0F;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPERAND,
        EXECUTE,
        STORE,
        JUMP,
        HALT
    } state_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: req/ack memory port between the control unit (master) and memory (slave).
// Latency: n/a (wiring only).
// Backpressure: master holds mem_rd/mem_wr and mem_addr until mem_ack is sampled high.
interface cpu_control_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_opcode_decode.sv
// cpu_opcode_decode: classifies an 8-bit opcode into the sequencer's dispatch controls.
// Latency: combinational.
// Backpressure: none.
module cpu_opcode_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       needs_operand,
    output logic       writes_acc,
    output logic       gate_acc,
    output logic       gate_x,
    output logic       is_store,
    output logic       is_jump,
    output logic       is_halt
);

    // Opcode classes; anything unlisted falls through as a NOP in the sequencer.
    always_comb begin
        needs_operand = ((opcode >= OP_LOAD) && (opcode <= OP_SUB)) ||
                        ((opcode >= OP_MPY)  && (opcode <= OP_NOTX));
        gate_x        = (opcode >= OP_SHL) && (opcode <= OP_NOTACC);
        writes_acc    = needs_operand || gate_x;
        gate_acc      = (opcode == OP_LOAD) || (opcode == OP_NOTX);
        is_store      = (opcode == OP_STORE);
        is_jump       = (opcode == OP_JMPGE) || (opcode == OP_JMP);
        is_halt       = (opcode == OP_HALT);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer feeding the ALU; optional SINGLE_STEP_EN adds a step input.
// Latency (zero-wait memory): NOP 2, register ALU/store/jump 3, operand ALU 4 cycles; +1 per memory wait cycle.
// Backpressure: memory requests and address held until mem_ack; with SINGLE_STEP_EN, fetch waits for a step pulse.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    cpu_control_unit_if.master mem,
    input  logic [DATA_W-1:0] acc_num,
    output logic [8:0]        fn,
    output logic              c7,
    output logic              c14,
    output logic [DATA_W-1:0] alu_x,
    output logic              acc_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

`ifdef SINGLE_STEP_EN
    // Returning to FETCH parks idle until the next step pulse.
    localparam logic FETCH_AUTO = 1'b0;
    logic fetch_go;
    assign fetch_go = step;
`else
    // Returning to FETCH issues the next read straight away.
    localparam logic FETCH_AUTO = 1'b1;
    logic fetch_go;
    assign fetch_go = 1'b1;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] alu_x_q, alu_x_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [8:0]        fn_q, fn_d;
    logic              c7_q, c7_d;
    logic              c14_q, c14_d;
    logic              acc_we_q, acc_we_d;
    logic              halted_q, halted_d;

    logic dec_operand, dec_writes, dec_gate_acc, dec_gate_x, dec_store, dec_jump, dec_halt;
    logic [ADDR_W-1:0] ir_addr;

    assign ir_addr = ir_q[ADDR_W-1:0];

    cpu_opcode_decode u_dec (
        .opcode        (ir_q[15:8]),
        .needs_operand (dec_operand),
        .writes_acc    (dec_writes),
        .gate_acc      (dec_gate_acc),
        .gate_x        (dec_gate_x),
        .is_store      (dec_store),
        .is_jump       (dec_jump),
        .is_halt       (dec_halt)
    );

    // Next-state logic; every output is computed one cycle ahead so the registers present it in the target state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_x_d  = alu_x_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;
        fn_d     = '0;
        c7_d     = 1'b1;
        c14_d    = 1'b1;
        acc_we_d = 1'b0;
        case (state_q)
            FETCH: begin
                if (rd_q) begin
                    if (mem.mem_ack) begin
                        ir_d    = mem.mem_rdata;
                        pc_d    = pc_q + ADDR_W'(1);
                        rd_d    = 1'b0;
                        state_d = DECODE;
                    end
                end else if (fetch_go) begin
                    rd_d   = 1'b1;
                    addr_d = pc_q;
                end
            end
            DECODE: begin
                if (dec_operand) begin
                    rd_d    = 1'b1;
                    addr_d  = ir_addr;
                    state_d = OPERAND;
                end else if (dec_store) begin
                    wr_d    = 1'b1;
                    addr_d  = ir_addr;
                    wdata_d = acc_num;
                    state_d = STORE;
                end else if (dec_jump) begin
                    state_d = JUMP;
                end else if (dec_halt) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (dec_writes) begin
                    fn_d     = {1'b0, ir_q[15:8]};
                    c7_d     = dec_gate_acc;
                    c14_d    = dec_gate_x;
                    acc_we_d = 1'b1;
                    state_d  = EXECUTE;
                end else begin
                    rd_d    = FETCH_AUTO;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            OPERAND: begin
                if (rd_q && mem.mem_ack) begin
                    alu_x_d  = mem.mem_rdata;
                    rd_d     = 1'b0;
                    fn_d     = {1'b0, ir_q[15:8]};
                    c7_d     = dec_gate_acc;
                    c14_d    = dec_gate_x;
                    acc_we_d = 1'b1;
                    state_d  = EXECUTE;
                end
            end
            EXECUTE: begin
                rd_d    = FETCH_AUTO;
                addr_d  = pc_q;
                state_d = FETCH;
            end
            STORE: begin
                if (wr_q && mem.mem_ack) begin
                    wr_d    = 1'b0;
                    rd_d    = FETCH_AUTO;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            JUMP: begin
                // JMPGE falls through on a negative ACC; pc already points past the jump.
                if ((ir_q[15:8] == OP_JMP) || !acc_num[DATA_W-1]) begin
                    pc_d = ir_addr;
                end
                rd_d    = FETCH_AUTO;
                addr_d  = pc_d;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also abandons any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            alu_x_q  <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            fn_q     <= '0;
            c7_q     <= 1'b1;
            c14_q    <= 1'b1;
            acc_we_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_x_q  <= alu_x_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            fn_q     <= fn_d;
            c7_q     <= c7_d;
            c14_q    <= c14_d;
            acc_we_q <= acc_we_d;
            halted_q <= halted_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd    = rd_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_wdata = wdata_q;
    assign fn            = fn_q;
    assign c7            = c7_q;
    assign c14           = c14_q;
    assign alu_x         = alu_x_q;
    assign acc_we        = acc_we_q;
    assign pc            = pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: runs directed and random programs, compares the DUT's bus/ALU event stream to an ISA-level model.
// Latency: n/a.
// Backpressure: memory responder inserts fixed or random wait states and stray idle acks.
module tb_cpu_control_unit;

    localparam logic [7:0] EV_RD  = 8'd1;
    localparam logic [7:0] EV_WR  = 8'd2;
    localparam logic [7:0] EV_EX  = 8'd3;
    localparam logic [7:0] EV_HLT = 8'd4;

    logic        clk;
    logic        rst;
    logic [15:0] acc_num;
    logic [8:0]  fn;
    logic        c7, c14, acc_we, halted;
    logic [15:0] alu_x;
    logic [7:0]  pc;

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (bus.master),
        .acc_num (acc_num),
        .fn      (fn),
        .c7      (c7),
        .c14     (c14),
        .alu_x   (alu_x),
        .acc_we  (acc_we),
        .pc      (pc),
        .halted  (halted)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    logic [63:0] exp_ev[$];
    int          exp_dl[$];
    int          exp_pf[$];
    logic        model_halt;
    logic [63:0] obs_ev[$];
    int          obs_cyc[$];
    int          obs_len[$];

    bit         mon_en = 0;
    bit         blk_en = 0;
    logic [7:0] blk_addr = 8'h00;
    int         fix_wait = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [63:0] ev(input logic [7:0] k, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c);
        return {8'h00, k, a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: acks after a fixed or random number of wait cycles; stray acks while idle.
    initial begin : responder
        int seen;
        int cur_wait;
        seen = 0;
        cur_wait = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                seen = 0;
            end
            if (!rst && (bus.mem_rd || bus.mem_wr)) begin
                if (seen == 0) cur_wait = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 2));
                if (seen >= cur_wait && !(blk_en && bus.mem_addr == blk_addr)) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_rd) bus.mem_rdata = mem[bus.mem_addr];
                    else mem[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    seen++;
                end
            end else begin
                seen = 0;
                bus.mem_rdata = 16'($urandom);
                bus.mem_ack = !rst && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor: turns completed transfers, ACC strobes and halt into an event stream.
    always @(negedge clk) begin : monitor
        static int req_len = 0;
        static bit hlt_seen = 0;
        if (rst) begin
            req_len = 0;
            hlt_seen = 0;
        end else if (mon_en) begin
            if (bus.mem_rd || bus.mem_wr) req_len++;
            if (bus.mem_ack && (bus.mem_rd || bus.mem_wr)) begin
                obs_ev.push_back(bus.mem_rd ? ev(EV_RD, {8'h00, bus.mem_addr}, 16'h0, 16'h0)
                                            : ev(EV_WR, {8'h00, bus.mem_addr}, bus.mem_wdata, 16'h0));
                obs_cyc.push_back(cyc);
                obs_len.push_back(req_len);
                req_len = 0;
            end
            if (acc_we) begin
                obs_ev.push_back(ev(EV_EX, {c7, c14, 5'b0, fn}, alu_x, {8'h00, pc}));
                obs_cyc.push_back(cyc);
                obs_len.push_back(0);
            end
            if (halted && !hlt_seen) begin
                hlt_seen = 1;
                obs_ev.push_back(ev(EV_HLT, {8'h00, pc}, 16'h0, 16'h0));
                obs_cyc.push_back(cyc);
                obs_len.push_back(0);
            end
        end
    end

    // Instruction-level model: expected transfers, ALU strobes and fetch-to-fetch cycle counts.
    task automatic model(input int max_instr, input logic [15:0] acc, input int w);
        logic [7:0]  p;
        logic [15:0] x;
        int prev_lat, prev_nreq, last_fetch;
        p = 8'h00;
        x = 16'h0000;
        prev_lat = -1;
        prev_nreq = 0;
        last_fetch = -1;
        model_halt = 1'b0;
        exp_ev.delete();
        exp_dl.delete();
        exp_pf.delete();
        for (int n = 0; n < max_instr && !model_halt; n++) begin
            logic [15:0] ins;
            logic [7:0]  op, a;
            int lat, nreq;
            ins = ref_mem[p];
            exp_ev.push_back(ev(EV_RD, {8'h00, p}, 16'h0, 16'h0));
            exp_dl.push_back((prev_lat < 0 || w < 0) ? -1 : prev_lat + prev_nreq * w);
            exp_pf.push_back(last_fetch);
            last_fetch = exp_ev.size() - 1;
            op = ins[15:8];
            a = ins[7:0];
            p = p + 8'd1;
            lat = 2;
            nreq = 1;
            if (op inside {8'h02, 8'h03, 8'h04, [8'h08:8'h0C]}) begin
                exp_ev.push_back(ev(EV_RD, {8'h00, a}, 16'h0, 16'h0));
                exp_dl.push_back(-1);
                exp_pf.push_back(-1);
                x = ref_mem[a];
                exp_ev.push_back(ev(EV_EX, {(op == 8'h02 || op == 8'h0C), 1'b0, 6'b0, op}, x, {8'h00, p}));
                exp_dl.push_back(-1);
                exp_pf.push_back(-1);
                lat = 4;
                nreq = 2;
            end else if (op inside {[8'h0D:8'h0F]}) begin
                exp_ev.push_back(ev(EV_EX, {1'b0, 1'b1, 6'b0, op}, x, {8'h00, p}));
                exp_dl.push_back(-1);
                exp_pf.push_back(-1);
                lat = 3;
            end else if (op == 8'h01) begin
                exp_ev.push_back(ev(EV_WR, {8'h00, a}, acc, 16'h0));
                exp_dl.push_back(-1);
                exp_pf.push_back(-1);
                ref_mem[a] = acc;
                lat = 3;
                nreq = 2;
            end else if (op == 8'h05 || op == 8'h06) begin
                if (op == 8'h06 || !acc[15]) p = a;
                lat = 3;
            end else if (op == 8'h07) begin
                exp_ev.push_back(ev(EV_HLT, {8'h00, p}, 16'h0, 16'h0));
                exp_dl.push_back(-1);
                exp_pf.push_back(-1);
                model_halt = 1'b1;
            end
            prev_lat = lat;
            prev_nreq = nreq;
        end
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk({name, "_rst_rd"}, bus.mem_rd, 1'b0);
        chk({name, "_rst_wr"}, bus.mem_wr, 1'b0);
        chk({name, "_rst_addr"}, bus.mem_addr, 8'h00);
        chk({name, "_rst_we"}, acc_we, 1'b0);
        chk({name, "_rst_ctl"}, {fn, c7, c14}, {9'h000, 1'b1, 1'b1});
        chk({name, "_rst_x"}, alu_x, 16'h0000);
        chk({name, "_rst_pc"}, pc, 8'h00);
        chk({name, "_rst_halt"}, halted, 1'b0);
    endtask

    // Releases reset with mem[] loaded, then compares the observed stream with the model.
    task automatic run_prog(input string name, input int w, input logic [15:0] acc, input int max_instr);
        int guard, rd_cnt;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        fix_wait = w;
        acc_num = acc;
        model(max_instr, acc, w);
        obs_ev.delete();
        obs_cyc.delete();
        obs_len.delete();
        mon_en = 1;
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        while (obs_ev.size() < exp_ev.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_done"}, obs_ev.size() >= exp_ev.size(), 1'b1);
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
            chk($sformatf("%s_ev%0d", name, i), obs_ev[i], exp_ev[i]);
            if (exp_dl[i] >= 0 && exp_pf[i] >= 0)
                chk($sformatf("%s_lat%0d", name, i), obs_cyc[i] - obs_cyc[exp_pf[i]], exp_dl[i]);
            if (w >= 0 && (exp_ev[i][55:48] == EV_RD || exp_ev[i][55:48] == EV_WR))
                chk($sformatf("%s_hold%0d", name, i), obs_len[i], w + 1);
        end
        if (model_halt) begin
            rd_cnt = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.mem_rd || bus.mem_wr) rd_cnt++;
            end
            chk({name, "_halt_quiet"}, rd_cnt, 0);
            chk({name, "_halt_flag"}, halted, 1'b1);
            chk({name, "_halt_count"}, obs_ev.size(), exp_ev.size());
        end
        mon_en = 0;
    endtask

    initial begin : main
        int guard;
        rst = 1'b1;
        acc_num = 16'h0000;

        do_reset("t1");
        clr_mem();
        mem[0] = 16'h0210;
        mem[8'h10] = 16'h1234;
        mem[1] = 16'h0700;
        run_prog("t1", 0, 16'h0000, 10);

        do_reset("t2");
        clr_mem();
        mem[0] = 16'h0111;
        mem[1] = 16'h0700;
        run_prog("t2", 3, 16'hBEEF, 10);

        do_reset("t3a");
        clr_mem();
        mem[0] = 16'h0540;
        mem[1] = 16'h0700;
        mem[8'h40] = 16'h0700;
        run_prog("t3a", 0, 16'h0001, 10);
        do_reset("t3b");
        run_prog("t3b", 0, 16'h8000, 10);

        do_reset("t4");
        clr_mem();
        mem[0] = 16'h06FE;
        mem[8'hFE] = 16'hAA00;
        mem[8'hFF] = 16'h0D00;
        run_prog("t4", 0, 16'h0000, 4);

        do_reset("t5");
        clr_mem();
        mem[0] = 16'h0230;
        mem[8'h30] = 16'h5555;
        blk_addr = 8'h30;
        blk_en = 1;
        fix_wait = 0;
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        while (!(bus.mem_rd && bus.mem_addr == 8'h30) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_operand_req", guard < 50, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5_operand_hold", {bus.mem_rd, bus.mem_addr}, {1'b1, 8'h30});
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort_rd", bus.mem_rd, 1'b0);
        chk("t5_abort_we", acc_we, 1'b0);
        blk_en = 0;
        do_reset("t5b");
        clr_mem();
        mem[0] = 16'hAA00;
        mem[1] = 16'h0700;
        run_prog("t5", 0, 16'h1111, 10);

        for (int r = 0; r < 24; r++) begin
            int w;
            do_reset($sformatf("r%0d", r));
            for (int i = 0; i < 256; i++) begin
                int k;
                logic [7:0] op;
                k = $urandom_range(0, 19);
                op = (k <= 15) ? 8'(k) : ((k == 16) ? 8'($urandom_range(16, 255)) : 8'h07);
                mem[i] = {op, 8'($urandom_range(0, 255))};
            end
            w = (r % 4 == 0) ? 0 : ((r % 4 == 1) ? 1 : -1);
            run_prog($sformatf("r%0d", r), w, 16'($urandom), 30);
        end

        do_reset("end");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
